// File: rtl/sram_burst_ctrl.sv
// Burst controller for an asynchronous SRAM: issues len+1 sequential read or write beats.
// Optional macro SRAM_BURST_TURNAROUND_EN adds a one-cycle bus turnaround after read bursts.
module sram_burst_ctrl #(
    parameter int AW      = 20,
    parameter int DW      = 8,
    parameter int LW      = 4,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          rw,
    input  logic [AW-1:0] addr,
    input  logic [LW-1:0] len,
    output logic          ready,
    input  logic [DW-1:0] wdata,
    output logic          wr_pop,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          ce_n,
    output logic          we_n,
    output logic          oe_n,
    output logic [AW-1:0] a,
    inout  wire  [DW-1:0] dq
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
    localparam logic [2:0] WH   = 3'd3;
`ifdef SRAM_BURST_TURNAROUND_EN
    localparam logic [2:0] TURN   = 3'd4;
    localparam logic [2:0] RD_END = TURN;
`else
    localparam logic [2:0] RD_END = IDLE;
`endif

    localparam logic [3:0]    RD_LAST = 4'(RD_WAIT);
    localparam logic [3:0]    WR_LAST = 4'(WR_WAIT);
    localparam logic [AW-1:0] A_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] C_ONE   = {{(LW-1){1'b0}}, 1'b1};

    logic [2:0]    state;
    logic [LW-1:0] cnt;
    logic [3:0]    wait_cnt;
    logic [DW-1:0] wr_data;
    logic          dq_oe;

    assign ready = (state == IDLE);
    // wdata is consumed on request acceptance and in the hold cycle of every non-final beat
    assign wr_pop = rst_n && (((state == IDLE) && req && !rw) ||
                              ((state == WH) && (cnt != '0)));
    assign dq = dq_oe ? wr_data : {DW{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            wait_cnt <= '0;
            wr_data  <= '0;
            dq_oe    <= 1'b0;
            a        <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
            ce_n     <= 1'b1;
            we_n     <= 1'b1;
            oe_n     <= 1'b1;
        end else begin
            rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        a        <= addr;
                        cnt      <= len;
                        wait_cnt <= '0;
                        ce_n     <= 1'b0;
                        if (rw) begin
                            state <= RD;
                            oe_n  <= 1'b0;
                        end else begin
                            state   <= WR;
                            we_n    <= 1'b0;
                            dq_oe   <= 1'b1;
                            wr_data <= wdata;
                        end
                    end
                end
                RD: begin
                    if (wait_cnt == RD_LAST) begin
                        rdata    <= dq;
                        rvalid   <= 1'b1;
                        wait_cnt <= '0;
                        a        <= a + A_ONE;
                        if (cnt == '0) begin
                            ce_n  <= 1'b1;
                            oe_n  <= 1'b1;
                            state <= RD_END;
                        end else begin
                            cnt <= cnt - C_ONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                WR: begin
                    if (wait_cnt == WR_LAST) begin
                        we_n     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WH;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                WH: begin
                    // data stays on dq for this cycle so the SRAM sees hold after we_n rises
                    a <= a + A_ONE;
                    if (cnt == '0) begin
                        ce_n  <= 1'b1;
                        dq_oe <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt     <= cnt - C_ONE;
                        we_n    <= 1'b0;
                        wr_data <= wdata;
                        state   <= WR;
                    end
                end
`ifdef SRAM_BURST_TURNAROUND_EN
                TURN: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Scoreboard bench for sram_burst_ctrl: directed bursts, read ROM model, write/read monitors.
// Honours SRAM_BURST_TURNAROUND_EN when computing ready timing.
module tb_sram_burst_ctrl;

    localparam int AW      = 20;
    localparam int DW      = 8;
    localparam int LW      = 4;
    localparam int RD_WAIT = 1;
    localparam int WR_WAIT = 0;
`ifdef SRAM_BURST_TURNAROUND_EN
    localparam int TURN_CYC = 1;
`else
    localparam int TURN_CYC = 0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          req   = 1'b0;
    logic          rw    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [LW-1:0] len   = '0;
    logic [DW-1:0] wdata = '0;
    logic          ready, wr_pop, rvalid, ce_n, we_n, oe_n;
    logic [DW-1:0] rdata;
    logic [AW-1:0] a;
    wire  [DW-1:0] dq;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int pop_cnt = 0;
    logic pop_pend  = 1'b0;
    logic prev_we_n = 1'b1;

    logic [DW+31:0]    rd_exp_q[$];
    logic [AW+DW+31:0] wr_exp_q[$];
    logic [DW-1:0]     wsrc_q[$];
    logic [DW+31:0]    rd_e;
    logic [AW+DW+31:0] wr_e;

    sram_burst_ctrl #(
        .AW(AW), .DW(DW), .LW(LW), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .addr(addr), .len(len),
        .ready(ready), .wdata(wdata), .wr_pop(wr_pop), .rdata(rdata), .rvalid(rvalid),
        .ce_n(ce_n), .we_n(we_n), .oe_n(oe_n), .a(a), .dq(dq)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // read-only SRAM model: contents are a fixed function of the address
    function automatic logic [DW-1:0] rom(input logic [AW-1:0] ad);
        return ad[7:0] ^ 8'h5A;
    endfunction

    assign dq = (!ce_n && !oe_n) ? rom(a) : {DW{1'bz}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: wdata supply, read scoreboard, write scoreboard, strobe exclusion
    always @(negedge clk) begin
        check("strobe_excl", {63'd0, (!we_n && !oe_n)}, 64'd0);
        if (pop_pend && wsrc_q.size() > 0) void'(wsrc_q.pop_front());
        pop_pend = wr_pop;
        if (wr_pop) pop_cnt++;
        wdata = (wsrc_q.size() > 0) ? wsrc_q[0] : '0;
        if (rvalid) begin
            if (rd_exp_q.size() == 0) begin
                check("rvalid_extra", 64'd1, 64'd0);
            end else begin
                rd_e = rd_exp_q.pop_front();
                check("rdata", rdata, rd_e[DW-1:0]);
                check("rvalid_cyc", cyc, rd_e[DW+31:DW]);
            end
        end
        if (!ce_n && we_n && !prev_we_n) begin
            if (wr_exp_q.size() == 0) begin
                check("write_extra", 64'd1, 64'd0);
            end else begin
                wr_e = wr_exp_q.pop_front();
                check("wr_addr", a, wr_e[AW+DW-1:DW]);
                check("wr_dq_hold", dq, wr_e[DW-1:0]);
                check("wr_cyc", cyc, wr_e[AW+DW+31:AW+DW]);
            end
        end
        prev_we_n = we_n;
    end

    // driver: present a request and push the expected beats; wsrc_q must hold the write data
    task automatic issue(input logic r, input logic [AW-1:0] ad, input logic [LW-1:0] ln,
                         output int acc);
        rw   = r;
        addr = ad;
        len  = ln;
        req  = 1'b1;
        acc  = cyc + 1;
        for (int k = 0; k <= int'(ln); k++) begin
            logic [AW-1:0] ak;
            ak = ad + AW'(k);
            if (r)
                rd_exp_q.push_back({32'(acc + (RD_WAIT + 1) * k + RD_WAIT + 1), rom(ak)});
            else
                wr_exp_q.push_back({32'(acc + (WR_WAIT + 2) * k + WR_WAIT + 1), ak, wsrc_q[k]});
        end
    endtask

    task automatic wait_ready(input string name, input int exp_cyc);
        int n;
        n = 0;
        while (!ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, cyc, exp_cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ce_n"}, ce_n, 1);
        check({tag, "_we_n"}, we_n, 1);
        check({tag, "_oe_n"}, oe_n, 1);
        check({tag, "_dq_drive"}, dut.dq_oe, 0);
        check({tag, "_a"}, a, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_rvalid"}, rvalid, 0);
        check({tag, "_wr_pop"}, wr_pop, 0);
    endtask

    initial begin
        int acc;
        int acc2;
        int p0;

        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 check("ready_after_reset", ready, 1);

        // read burst of 4 at 0x10
        issue(1'b1, 20'h00010, 4'd3, acc);
        @(posedge clk); #1 req = 1'b0;
        wait_ready("rd_burst_ready", acc + 8 + TURN_CYC);

        // single write 0xA5 at 0x10
        wsrc_q.push_back(8'hA5);
        issue(1'b0, 20'h00010, 4'd0, acc);
        @(posedge clk); #1 req = 1'b0;
        check("wr1_we_n", we_n, 0);
        check("wr1_a", a, 20'h00010);
        check("wr1_dq", dq, 8'hA5);
        wait_ready("wr1_ready", acc + 2);

        // write burst wrapping through the top of the address space
        wsrc_q.push_back(8'h11); wsrc_q.push_back(8'h22);
        wsrc_q.push_back(8'h33); wsrc_q.push_back(8'h44);
        p0 = pop_cnt;
        issue(1'b0, 20'hFFFFE, 4'd3, acc);
        @(posedge clk); #1 req = 1'b0;
        wait_ready("wrap_ready", acc + 8);
        check("wrap_pops", pop_cnt - p0, 4);

        // req held high across a busy read burst
        issue(1'b1, 20'h00020, 4'd2, acc);
        @(posedge clk); #1 addr = 20'h00040;
        wait_ready("busy_ready", acc + 6 + TURN_CYC);
        issue(1'b1, 20'h00040, 4'd2, acc2);
        @(posedge clk); #1 req = 1'b0;
        wait_ready("busy2_ready", acc2 + 6 + TURN_CYC);

        // read followed immediately by a write request
        issue(1'b1, 20'h00005, 4'd0, acc);
        @(posedge clk); #1 req = 1'b0;
        wait_ready("turn_ready", acc + 2 + TURN_CYC);
        wsrc_q.push_back(8'h5C); wsrc_q.push_back(8'hC5);
        issue(1'b0, 20'h00030, 4'd1, acc);
        @(posedge clk); #1 req = 1'b0;
        wait_ready("turn_wr_ready", acc + 4);

        // reset during beat 1 of a 4-beat write
        wsrc_q.push_back(8'h01); wsrc_q.push_back(8'h02);
        wsrc_q.push_back(8'h03); wsrc_q.push_back(8'h04);
        p0 = pop_cnt;
        issue(1'b0, 20'h00040, 4'd3, acc);
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        wsrc_q.delete();
        wr_exp_q.delete();
        check("midrst_pops", pop_cnt - p0, 2);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 check("midrst_ready", ready, 1);
        repeat (4) @(posedge clk);
        #1 check("midrst_no_more_pops", pop_cnt - p0, 2);

        // recovery read after the aborted burst
        issue(1'b1, 20'h00013, 4'd0, acc);
        @(posedge clk); #1 req = 1'b0;
        wait_ready("recover_ready", acc + 2 + TURN_CYC);

        repeat (3) @(posedge clk);
        #1;
        check("rd_queue_empty", rd_exp_q.size(), 0);
        check("wr_queue_empty", wr_exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_burst_ctrl.md
SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 SHALL have parameter AW, default 20, meaning SRAM address width.
REQ-002 SHALL have parameter DW, default 8, meaning SRAM data width.
REQ-003 SHALL have parameter LW, default 4, meaning burst-length field width; a burst is len+1 beats, 1..2^LW.
REQ-004 SHALL have parameter RD_WAIT, default 1, meaning extra oe_n-low cycles per read beat, 0..15.
REQ-005 SHALL have parameter WR_WAIT, default 0, meaning extra we_n-low cycles per write beat, 0..15.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-008 SHALL have port req, input, 1, request to start a burst.
REQ-009 SHALL have port rw, input, 1, burst direction: 1 = read, 0 = write.
REQ-010 SHALL have port addr, input, AW, burst start address.
REQ-011 SHALL have port len, input, LW, beats minus one.
REQ-012 SHALL have port ready, output, 1, idle and able to accept req.
REQ-013 SHALL have port wdata, input, DW, write data; it must be valid whenever wr_pop is high.
REQ-014 SHALL have port wr_pop, output, 1, pulse: wdata is consumed this cycle.
REQ-015 SHALL have port rdata, output, DW, registered read data.
REQ-016 SHALL have port rvalid, output, 1, pulse: rdata holds a new beat.
REQ-017 SHALL have port ce_n, output, 1, SRAM chip enable.
REQ-018 SHALL have port we_n, output, 1, SRAM write enable.
REQ-019 SHALL have port oe_n, output, 1, SRAM output enable.
REQ-020 SHALL have port a, output, AW, SRAM address.
REQ-021 SHALL have port dq, inout, DW, SRAM data bus.

Function
REQ-022 States SHALL be IDLE, RD, WR, WH and (when enabled) TURN; ready SHALL be 1 only in IDLE.
REQ-023 In IDLE, req=1 SHALL latch addr, len and rw, and move to RD when rw=1 or WR when rw=0; if rw=0, wr_pop SHALL be 1 in the same cycle and wdata SHALL be latched.
REQ-024 req SHALL be ignored in every state other than IDLE.
REQ-025 RD SHALL last RD_WAIT+1 cycles per beat with ce_n=0, oe_n=0 and dq high-Z.
REQ-026 On the last RD cycle of a beat, dq SHALL be captured into rdata, and rvalid SHALL be 1 in the following cycle for exactly one cycle.
REQ-027 WR SHALL last WR_WAIT+1 cycles per beat with ce_n=0, we_n=0 and dq driven from latched data.
REQ-028 WH SHALL last 1 cycle with we_n=1, ce_n=0 and dq still driven, to provide data hold.
REQ-029 In WH of a non-final beat, wr_pop SHALL be 1 and wdata SHALL be latched for the next beat.
REQ-030 After each beat, a SHALL increment by 1 modulo 2^AW, so the address wraps from all-ones to 0 without error.
REQ-031 The beat counter SHALL load len and decrement per beat; after the beat completed at count 0, the FSM SHALL return to IDLE.
REQ-032 Back-to-back beats within a burst SHALL have no idle cycles: read beats are RD_WAIT+1 cycles apart, write beats are WR_WAIT+2 cycles apart.
REQ-033 In IDLE, ce_n, we_n and oe_n SHALL be 1 and dq SHALL be high-Z.
REQ-034 we_n and oe_n SHALL never both be 0.
REQ-035 All SRAM-side outputs SHALL be driven directly from flops.

Reset
REQ-036 Assertion of rst_n=0 SHALL immediately, without waiting for clk, force: state IDLE, ce_n=we_n=oe_n=1, dq high-Z, a=0, rdata=0, rvalid=0, wr_pop=0, and counters 0.
REQ-037 Reset asserted mid-burst SHALL abandon the burst; no further rvalid or wr_pop SHALL occur for it.
REQ-038 ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-039 With SRAM_BURST_TURNAROUND_EN defined, a 1-cycle TURN state (all strobes high, dq high-Z) SHALL be inserted between the end of a read burst and the acceptance of the next request.
REQ-040 Without SRAM_BURST_TURNAROUND_EN, the FSM SHALL return directly to IDLE and TURN SHALL not exist.

Verification
REQ-041 Single write: AW=20, DW=8, WR_WAIT=0, addr=0x00010, len=0, wdata=0xA5 -> we_n low 1 cycle, a=0x00010, dq=0xA5 through WH, ready returns after 2 cycles.
REQ-042 Read burst: RD_WAIT=1, addr=0x00010, len=3, SRAM model preloaded -> four rvalid pulses 2 cycles apart, a=0x10..0x13, rdata matches the model.
REQ-043 Wrap: addr=0xFFFFE, len=3, write -> a sequence is 0xFFFFE, 0xFFFFF, 0x00000, 0x00001, with 4 wr_pop pulses.
REQ-044 Busy: req held high throughout a len=2 read -> exactly one burst executes; a second burst starts only on the first ready=1 cycle.
REQ-045 Reset mid write burst: rst_n low during beat 1 of len=3 -> same-cycle strobes high, dq high-Z, no further wr_pop.
REQ-046 Macro: read burst followed by immediate write req -> with SRAM_BURST_TURNAROUND_EN, ready is delayed 1 cycle; without it, no delay.
